mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative HI/LO multiply/divide unit in the EX stage of PipeCPU; executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Results land in HI/LO (64-bit product = {hi,lo}), read back by MFHI/MFLO. The pipeline stalls on busy.
// PARAMETERS
//  ITER_BITS  1  quotient/product bits retired per RUN cycle; legal 1,2,4; N = 32/ITER_BITS RUN cycles
// PORTS
//  clk     in   1   system clock, all state on posedge
//  reset   in   1   synchronous, active-high; clears all state
//  start   in   1   request; sampled only when busy==0
//  op      in   3   MDU_MULT/MULTU/DIV/DIVU/MTHI/MTLO (codes from shared header)
//  a       in   32  rs value (multiplicand / dividend / MTxx data)
//  b       in   32  rt value (multiplier / divisor)
//  cancel  in   1   abort in-flight op (EX flush); HI/LO untouched
//  busy    out  1   op in flight; CPU holds MFHI/MFLO/next MDU op while high
//  done    out  1   one-cycle pulse: HI/LO just updated by MULT/DIV
//  hi      out  32  HI register
//  lo      out  32  LO register
// BEHAVIOUR
//  - Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, internal acc/operands=0. Reset mid-op discards op.
//  - FSM: IDLE -> PREP -> RUN(xN) -> FIX -> IDLE.
//  - IDLE: start&&op=MTHI -> hi<=a next edge; MTLO -> lo<=a; no busy, no done. MULT* / DIV* -> PREP.
//  - PREP: latch |a|,|b| (signed ops) or raw (unsigned); record result signs; busy=1.
//  - RUN: mult = shift-add, div = restoring shift-subtract, ITER_BITS per cycle, 64-bit accumulator.
//  - FIX: apply sign (product negated if sign(a)^sign(b); quotient likewise; remainder takes sign(a));
//    write hi/lo at the FIX edge; done=1 the following cycle; busy drops the same cycle.
//  - Latency: start cycle = 0; busy high cycles 1..N+2; new hi/lo and done visible cycle N+3 (N=32 -> 35).
//  - start while busy: ignored (no queueing). Unknown op codes: ignored.
//  - cancel: any state -> IDLE next edge, busy=0, done=0, hi/lo unchanged. cancel&&start in IDLE: start ignored.
//  - Divide by zero: lo=32'hFFFF_FFFF, hi=a; same latency. DIV 0x8000_0000 / -1: lo=0x8000_0000, hi=0.
//  - Arithmetic: products exact 64-bit two's complement; -2^31 magnitude handled as 33-bit unsigned.
// CONFIGURATION
//  MDU_DIV_EN defined: DIV/DIVU implemented as above.
//  MDU_DIV_EN undefined: divider datapath absent; DIV/DIVU treated as unknown ops (ignored, no busy,
//  hi/lo unchanged); MULT/MULTU/MTHI/MTLO unaffected.
// STRUCTURE
//  Shared header (alongside ISA.v): MDU op codes, FSM state encodings, MDU_W=32 constant.
//  One sub-module: mdu_iter_core -- combinational ITER_BITS step for shift-add/shift-subtract;
//  mul_div_unit holds FSM, sign handling, HI/LO registers.
// TESTING
//  1 MULTU a=111111 b=222222 -> cycle 35 done, hi=32'h0000_0005, lo=32'hBFB7_7862.
//  2 MULT a=-111111 b=222222 -> hi=32'hFFFF_FFFA, lo=32'h4048_879E; MULT a=b=32'h8000_0000 -> hi=32'h4000_0000, lo=0.
//  3 DIV a=-7 b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF; DIVU a=100 b=7 -> lo=14, hi=2; DIV a=5 b=0 -> lo=FFFF_FFFF, hi=5.
//  4 MULTU 3*4, assert cancel on cycle 10 -> busy=0 cycle 11, no done, hi/lo keep prior values; MTLO 9 -> lo=9 next cycle.
//  5 start MULT while busy, then reset on cycle 20 -> second request ignored; after reset hi=lo=0, busy=0.
//  6 Sweep ITER_BITS=1,2,4 with random 1000 ops vs $signed/$unsigned model; done at cycle N+3 each time.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states, datapath width.
// The divider is built only when MDU_DIV_EN is defined.
package mul_div_unit_pkg;

  localparam int MDU_W = 32;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_RUN  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  // Magnitude of a possibly signed operand; 2^31 still fits in 32 unsigned bits.
  function automatic logic [MDU_W-1:0] mdu_mag(input logic [MDU_W-1:0] v, input logic sgn);
    mdu_mag = (sgn && v[MDU_W-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit_iter_core.sv
// Combinational ITER_BITS-step slice: shift-add multiply or restoring shift-subtract divide
// on a 64-bit accumulator. The divide path exists only when MDU_DIV_EN is defined.
module mdu_iter_core
  import mul_div_unit_pkg::*;
#(
  parameter int ITER_BITS = 1
) (
`ifdef MDU_DIV_EN
  input  logic               is_div_i,
`endif
  input  logic [MDU_W-1:0]   opnd_i,
  input  logic [2*MDU_W-1:0] acc_i,
  output logic [2*MDU_W-1:0] acc_o
);

  logic [2*MDU_W-1:0] acc_s;
  logic [MDU_W:0]     sum_s;

  always_comb begin
    acc_s = acc_i;
    sum_s = '0;
    for (int i = 0; i < ITER_BITS; i++) begin
`ifdef MDU_DIV_EN
      if (is_div_i) begin
        // acc = {remainder, dividend bits still to shift in}; quotient bits enter at the LSB.
        sum_s = acc_s[2*MDU_W-1:MDU_W-1] - {1'b0, opnd_i};
        if (!sum_s[MDU_W]) begin
          acc_s = {sum_s[MDU_W-1:0], acc_s[MDU_W-2:0], 1'b1};
        end else begin
          acc_s = {acc_s[2*MDU_W-2:0], 1'b0};
        end
      end else begin
        sum_s = {1'b0, acc_s[2*MDU_W-1:MDU_W]} + (acc_s[0] ? {1'b0, opnd_i} : 33'd0);
        acc_s = {sum_s, acc_s[MDU_W-1:1]};
      end
`else
      sum_s = {1'b0, acc_s[2*MDU_W-1:MDU_W]} + (acc_s[0] ? {1'b0, opnd_i} : 33'd0);
      acc_s = {sum_s, acc_s[MDU_W-1:1]};
`endif
    end
    acc_o = acc_s;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative HI/LO multiply/divide unit: FSM, sign handling and HI/LO registers.
// Define MDU_DIV_EN to build DIV/DIVU; otherwise those codes are ignored like unknown ops.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int ITER_BITS = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [MDU_W-1:0] a_i,
  input  logic [MDU_W-1:0] b_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [MDU_W-1:0] hi_o,
  output logic [MDU_W-1:0] lo_o
);

  localparam int N = MDU_W / ITER_BITS;

  mdu_state_e         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [MDU_W-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [2*MDU_W-1:0] acc_q, acc_d, core_acc_s, prod_s;
  logic [5:0]         cnt_q, cnt_d;
  logic [MDU_W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               signed_s, is_div_s, neg_s;

  assign signed_s = (op_q == MDU_MULT) || (op_q == MDU_DIV);
  assign neg_s    = signed_s && (a_q[MDU_W-1] ^ b_q[MDU_W-1]);
  assign prod_s   = neg_s ? (~acc_q + 64'd1) : acc_q;

`ifdef MDU_DIV_EN
  logic [MDU_W-1:0] quo_s, rem_s;
  assign is_div_s = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
  assign quo_s    = neg_s ? (~acc_q[MDU_W-1:0] + 32'd1) : acc_q[MDU_W-1:0];
  // Remainder follows the dividend's sign.
  assign rem_s    = (signed_s && a_q[MDU_W-1]) ? (~acc_q[2*MDU_W-1:MDU_W] + 32'd1)
                                               : acc_q[2*MDU_W-1:MDU_W];
`else
  assign is_div_s = 1'b0;
`endif

  mdu_iter_core #(.ITER_BITS(ITER_BITS)) u_core (
`ifdef MDU_DIV_EN
    .is_div_i (is_div_s),
`endif
    .opnd_i   (opnd_q),
    .acc_i    (acc_q),
    .acc_o    (core_acc_s)
  );

  // Next-state logic: op acceptance, operand preparation, iteration and result fix-up.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (cancel_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            case (op_i)
              MDU_MTHI: hi_d = a_i;
              MDU_MTLO: lo_d = a_i;
`ifdef MDU_DIV_EN
              MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
`else
              MDU_MULT, MDU_MULTU: begin
`endif
                op_d    = op_i;
                a_d     = a_i;
                b_d     = b_i;
                state_d = ST_PREP;
              end
              default: state_d = ST_IDLE;
            endcase
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PREP: begin
          if (is_div_s) begin
            opnd_d = mdu_mag(b_q, signed_s);
            acc_d  = {32'd0, mdu_mag(a_q, signed_s)};
          end else begin
            opnd_d = mdu_mag(a_q, signed_s);
            acc_d  = {32'd0, mdu_mag(b_q, signed_s)};
          end
          cnt_d   = 6'd0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          acc_d = core_acc_s;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'(N - 1)) begin
            state_d = ST_FIX;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FIX: begin
`ifdef MDU_DIV_EN
          if (is_div_s) begin
            if (b_q == 32'd0) begin
              hi_d = a_q;
              lo_d = 32'hFFFF_FFFF;
            end else begin
              hi_d = rem_s;
              lo_d = quo_s;
            end
          end else begin
            {hi_d, lo_d} = prod_s;
          end
`else
          {hi_d, lo_d} = prod_s;
`endif
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and HI/LO registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      opnd_q  <= 32'd0;
      acc_q   <= 64'd0;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule
